bit_serializer: RTL

Parallel-to-serial source stage that sits directly upstream of the 1001 Moore sequence detector. It accepts WIDTH-bit words through a load/ready handshake and buffers them in a DEPTH-entry FIFO. It then drives them out one bit per clock on `x`, with no gaps between back-to-back words. When no word is being shifted, it holds `x` at 0, which keeps the downstream detector in its start state.

---
 rtl/bit_serializer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial source stage feeding the 1001 detector.
// Words enter through a load/ready handshake into a DEPTH-entry FIFO. They
// leave one bit per clock on x, with no idle cycles between queued words.
// x rests at 0 whenever no word is in flight.
// Optional build macro: BIT_SER_LSB_FIRST_EN. When it is defined, words are
// emitted LSB first. When it is undefined, they are emitted MSB first.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             x_q, x_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_q, last_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] word_in;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             take_head;

    // Words are stored in emission order, so the shifter always sends the
    // top bit first. LSB-first builds mirror the word on its way in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
`ifdef BIT_SER_LSB_FIRST_EN
            assign word_in[gi] = din[WIDTH-1-gi];
`else
            assign word_in[gi] = din[gi];
`endif
        end
    endgenerate

    // Ready depends only on the occupancy before the edge. It has no path
    // from load.
    assign ready = (count_q != FULL);
    assign push  = load && ready;
    assign head  = mem[rd_ptr_q];

    // FIFO storage. It has no reset, because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= word_in;
        end
    end

    // Next-state logic for the shifter FSM and the FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        x_d         = x_q;
        bit_valid_d = bit_valid_q;
        last_d      = last_q;
        take_head   = 1'b0;

        case (state_q)
            IDLE: begin
                x_d         = 1'b0;
                bit_valid_d = 1'b0;
                last_d      = 1'b0;
                if (count_q != '0) begin
                    take_head = 1'b1;
                end
            end
            SHIFT: begin
                if (bitcnt_q != '0) begin
                    shreg_d     = shreg_q << 1;
                    bitcnt_d    = bitcnt_q - BW'(1);
                    x_d         = shreg_q[WIDTH-1];
                    bit_valid_d = 1'b1;
                    last_d      = (bitcnt_q == BW'(1));
                end else if (count_q != '0) begin
                    // Chain straight into the next word so no gap appears.
                    take_head = 1'b1;
                end else begin
                    state_d     = IDLE;
                    x_d         = 1'b0;
                    bit_valid_d = 1'b0;
                    last_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                x_d         = 1'b0;
                bit_valid_d = 1'b0;
                last_d      = 1'b0;
            end
        endcase

        if (take_head) begin
            state_d     = SHIFT;
            shreg_d     = {head[WIDTH-2:0], 1'b0};
            bitcnt_d    = BIT_LAST;
            x_d         = head[WIDTH-1];
            bit_valid_d = 1'b1;
            last_d      = (WIDTH == 1);
        end

        pop      = take_head;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // State and output registers. An asynchronous reset drops the word in
    // flight and everything buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            x_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            x_q         <= x_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign x         = x_q;
    assign bit_valid = bit_valid_q;
    assign last      = last_q;
    assign busy      = (state_q == SHIFT) || (count_q != '0);

endmodule
